adder4_unit: RTL and testbench



---
 rtl/adder4_pkg.sv | 14 +
 rtl/adder4_unit_full_adder.sv | 13 +
 rtl/adder4_unit.sv | 90 +++++++++
 tb/tb_adder4_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/adder4_pkg.sv
// Shared constants and types for the registered 4-bit adder.
package adder4_pkg;

   // Operand width. The carry network and the ripple chain are written for 4 bits only.
   localparam int ADDER4_W = 4;

   // Registered result, packed as {cout, ovf, sum}.
   typedef struct packed {
      logic                cout;
      logic                ovf;
      logic [ADDER4_W-1:0] sum;
   } result_t;

endpackage : adder4_pkg

// File: rtl/adder4_unit_full_adder.sv
// One-bit full adder. It is the ripple-chain building block of adder4_unit.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder

// File: rtl/adder4_unit.sv
// Registered 4-bit adder with carry-in, carry-out and signed-overflow flag.
// There is one cycle of latency, and the result is captured under in_valid.
// Build option: `define ADDER4_CLA_EN selects a carry-lookahead core.
// Without it, the core is a ripple chain of full_adder instances.
// Both cores give identical results.
module adder4_unit
   import adder4_pkg::*;
#(
   parameter int WIDTH = ADDER4_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // c[i] is the carry into bit i. c[0] is cin and c[4] is the carry out of bit 3.
   logic [ADDER4_W:0]   c;
   logic [ADDER4_W-1:0] s;

   result_t res_d, res_q;
   logic    out_valid_d, out_valid_q;

   assign c[0] = cin;

`ifdef ADDER4_CLA_EN
   logic [ADDER4_W-1:0] g, p;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat sum-of-products of g, p and cin, so no carry waits on another.
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = p ^ c[ADDER4_W-1:0];
`else
   // The carry out of each stage feeds the carry in of the next stage.
   for (genvar i = 0; i < ADDER4_W; i++) begin : g_ripple
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end
`endif

   // Build the next-state result and valid from the core output.
   // Overflow is the carry into the sign bit XOR the carry out of the sign bit.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path infers a latch.
      res_d       = res_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         res_d.sum  = s;
         res_d.cout = c[ADDER4_W];
         res_d.ovf  = c[ADDER4_W] ^ c[ADDER4_W-1];
      end
   end

   // Output register with synchronous reset. Reset has priority over in_valid.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
      if (rst) begin
         res_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         res_q       <= res_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = res_q.sum;
   assign cout      = res_q.cout;
   assign ovf       = res_q.ovf;

endmodule : adder4_unit

// File: tb/tb_adder4_unit.sv
// Self-checking bench for adder4_unit. It uses directed vectors, corner
// sequences and an exhaustive stream.
module tb_adder4_unit;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       cin;
      logic [3:0] exp_sum;
      logic       exp_cout;
      logic       exp_ovf;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] a, b;
   logic       cin;
   logic       out_valid;
   logic [3:0] sum;
   logic       cout;
   logic       ovf;

   int n_checks = 0;
   int n_errors = 0;

   vec_t vecs[9];

   adder4_unit dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string name, input logic v, input logic [3:0] s,
                            input logic co, input logic o);
      check({name, ".out_valid"}, 32'(out_valid), 32'(v));
      check({name, ".sum"},       32'(sum),       32'(s));
      check({name, ".cout"},      32'(cout),      32'(co));
      check({name, ".ovf"},       32'(ovf),       32'(o));
   endtask

   // Inputs are driven at the falling edge and take effect at the next rising edge.
   // Outputs are then sampled at the following falling edge.
   task automatic drive(input logic r, input logic v, input logic [3:0] av,
                        input logic [3:0] bv, input logic c);
      rst      = r;
      in_valid = v;
      a        = av;
      b        = bv;
      cin      = c;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [4:0] ref5;
      logic       ref_ovf;

      vecs[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      vecs[1] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
      vecs[2] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
      vecs[3] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
      vecs[4] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
      vecs[5] = '{4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1};
      vecs[6] = '{4'h9, 4'h6, 1'b1, 4'h0, 1'b1, 1'b0};
      vecs[7] = '{4'hC, 4'hC, 1'b0, 4'h8, 1'b1, 1'b0};
      vecs[8] = '{4'h8, 4'hF, 1'b0, 4'h7, 1'b1, 1'b1};

      rst = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'hF; cin = 1'b0;
      @(negedge clk);

      // Reset overrides a valid input for two cycles.
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
         check_out("reset", 1'b0, 4'h0, 1'b0, 1'b0);
      end

      // rst falls here. Before the next edge the outputs still hold reset values.
      rst = 1'b0;
      #1;
      check_out("reset_release_pre", 1'b0, 4'h0, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check_out("reset_release_first", 1'b1, 4'hE, 1'b1, 1'b0);

      // Directed table, applied back to back.
      foreach (vecs[i]) begin
         drive(1'b0, 1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
         check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
      end

      // Valid gap: the result holds and out_valid drops. Ignored operands do not leak.
      drive(1'b0, 1'b1, 4'h3, 4'h4, 1'b0);
      check_out("gap_load", 1'b1, 4'h7, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'h9, 4'h9, 1'b1);
      check_out("gap_hold", 1'b0, 4'h7, 1'b0, 1'b0);

      // Hold with cout and ovf set.
      drive(1'b0, 1'b1, 4'h8, 4'h8, 1'b0);
      check_out("hold_flags_load", 1'b1, 4'h0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 4'h1, 4'h2, 1'b0);
      check_out("hold_flags_gap1", 1'b0, 4'h0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 4'h7, 4'h7, 1'b1);
      check_out("hold_flags_gap2", 1'b0, 4'h0, 1'b1, 1'b1);

      // Exhaustive stream. The reference uses the sign-bit form of overflow.
      for (int k = 0; k < 512; k++) begin
         logic [3:0] ea, eb;
         logic       ec;
         ea = k[3:0];
         eb = k[7:4];
         ec = k[8];
         ref5    = {1'b0, ea} + {1'b0, eb} + {4'b0, ec};
         ref_ovf = (ea[3] == eb[3]) && (ref5[3] != ea[3]);
         drive(1'b0, 1'b1, ea, eb, ec);
         check_out($sformatf("exh_%0h_%0h_%0b", ea, eb, ec), 1'b1, ref5[3:0], ref5[4], ref_ovf);
      end

      // Reset after a nonzero result clears the outputs and discards the valid input.
      drive(1'b1, 1'b1, 4'h7, 4'h1, 1'b0);
      check_out("reset_clear", 1'b0, 4'h0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 4'h2, 4'h2, 1'b1);
      check_out("after_reset", 1'b1, 4'h5, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_adder4_unit
